// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scan decoder: segment patterns
// (identical to the ones the meter's encoder drives), digit codes, the anode
// active level and small arithmetic helpers.
package sevenseg_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Digit codes beyond 0-9
    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_BAD   = 4'hE;

    // Anodes are driven low to light a digit
    localparam logic ANODE_ON = 1'b0;

    // Classification of the sampled anode vector
    typedef enum logic [1:0] {
        SEL_IDLE  = 2'd0,
        SEL_ONE   = 2'd1,
        SEL_MULTI = 2'd2
    } sel_kind_e;

    // True when a digit code is a decimal digit 0-9
    function automatic logic is_decimal(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

    // Weighted decimal value of four digit codes (d1 most significant)
    function automatic logic [13:0] weighted_value(input logic [3:0] d1,
                                                   input logic [3:0] d2,
                                                   input logic [3:0] d3,
                                                   input logic [3:0] d4);
        return (14'(d1) * 14'd1000) + (14'(d2) * 14'd100) +
               (14'(d3) * 14'd10) + 14'(d4);
    endfunction

endpackage

// File: rtl/sevenseg_scan_decoder_seg7_to_bcd.sv
// Combinational decoder from an active-low seven-segment pattern to a digit
// code. Blank decodes to CODE_BLANK, anything unrecognised to CODE_BAD with
// valid low.
module seg7_to_bcd
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] code,
    output logic       valid
);

    // Map each known pattern onto its code; unknown patterns are flagged bad
    always_comb begin
        code  = CODE_BAD;
        valid = 1'b0;
        case (seg_n)
            SEG_0:     begin code = 4'd0;       valid = 1'b1; end
            SEG_1:     begin code = 4'd1;       valid = 1'b1; end
            SEG_2:     begin code = 4'd2;       valid = 1'b1; end
            SEG_3:     begin code = 4'd3;       valid = 1'b1; end
            SEG_4:     begin code = 4'd4;       valid = 1'b1; end
            SEG_5:     begin code = 4'd5;       valid = 1'b1; end
            SEG_6:     begin code = 4'd6;       valid = 1'b1; end
            SEG_7:     begin code = 4'd7;       valid = 1'b1; end
            SEG_8:     begin code = 4'd8;       valid = 1'b1; end
            SEG_9:     begin code = 4'd9;       valid = 1'b1; end
            SEG_BLANK: begin code = CODE_BLANK; valid = 1'b1; end
            default:   begin code = CODE_BAD;   valid = 1'b0; end
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Seven-segment scan decoder: samples the multiplexed anode/segment bus,
// captures each digit after it has been stable for STABLE_CYC samples,
// commits a frame once all four digits are captured, and reports the binary
// value, blank frames, bus errors and a stale-display timeout.
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int unsigned STABLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a1,
    input  logic        a2,
    input  logic        a3,
    input  logic        a4,
    input  logic [6:0]  led_seg,
    output logic [3:0]  val1,
    output logic [3:0]  val2,
    output logic [3:0]  val3,
    output logic [3:0]  val4,
    output logic [13:0] value,
    output logic        value_ok,
    output logic        frame_done,
    output logic        blank_frame,
    output logic        seg_err,
    output logic        stale
);

    localparam int unsigned       STAB_W   = $clog2(STABLE_CYC + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC);
    // CNT_W must be wide enough for TIMEOUT_CYC or this cast truncates
    localparam logic [CNT_W-1:0]  TMO_MAX  = CNT_W'(TIMEOUT_CYC);
    localparam logic [3:0]        AN_IDLE  = {4{~ANODE_ON}};

    // Sample stage; anode vectors are {a4,a3,a2,a1} so bit i is digit i+1
    logic [3:0]        samp_an_d,  samp_an_q;
    logic [6:0]        samp_seg_d, samp_seg_q;
    logic [3:0]        prev_an_d,  prev_an_q;
    logic [6:0]        prev_seg_d, prev_seg_q;
    logic [STAB_W-1:0] stab_cnt_d, stab_cnt_q;

    // Frame assembly and committed outputs
    logic [3:0]        mask_d, mask_q;
    logic [3:0][3:0]   shadow_d, shadow_q;
    logic [3:0][3:0]   val_d, val_q;
    logic [13:0]       value_d, value_q;
    logic              value_ok_d, value_ok_q;
    logic              frame_done_d, frame_done_q;
    logic              blank_frame_d, blank_frame_q;
    logic              seg_err_d, seg_err_q;

    // Timeout
    logic [CNT_W-1:0]  tmo_cnt_d, tmo_cnt_q;
    logic              stale_d, stale_q;

    // Combinational helpers
    logic [3:0]        active_s;
    sel_kind_e         sel_kind_s;
    logic [1:0]        sel_idx_s;
    logic              same_s;
    logic              capture_s;
    logic              commit_s;
    logic [3:0]        dec_code_s;
    logic              dec_valid_s;
    logic              all_dec_s;
    logic              all_blank_s;
    logic [13:0]       sum_s;

    seg7_to_bcd u_dec (
        .seg_n (samp_seg_q),
        .code  (dec_code_s),
        .valid (dec_valid_s)
    );

    // Register the raw bus and keep the previous sample for the stability compare
    always_comb begin
        samp_an_d  = {a4, a3, a2, a1};
        samp_seg_d = led_seg;
        prev_an_d  = samp_an_q;
        prev_seg_d = samp_seg_q;
    end

    // Classify the sampled anodes: idle, exactly one digit lit, or a collision
    always_comb begin
        sel_kind_s = SEL_MULTI;
        sel_idx_s  = 2'd0;
        if (ANODE_ON == 1'b0) begin
            active_s = ~samp_an_q;
        end else begin
            active_s = samp_an_q;
        end
        case (active_s)
            4'b0000: begin sel_kind_s = SEL_IDLE;  sel_idx_s = 2'd0; end
            4'b0001: begin sel_kind_s = SEL_ONE;   sel_idx_s = 2'd0; end
            4'b0010: begin sel_kind_s = SEL_ONE;   sel_idx_s = 2'd1; end
            4'b0100: begin sel_kind_s = SEL_ONE;   sel_idx_s = 2'd2; end
            4'b1000: begin sel_kind_s = SEL_ONE;   sel_idx_s = 2'd3; end
            default: begin sel_kind_s = SEL_MULTI; sel_idx_s = 2'd0; end
        endcase
    end

    // Stability counter: capture once per dwell when it first reaches STABLE_CYC
    always_comb begin
        same_s = (samp_an_q == prev_an_q) && (samp_seg_q == prev_seg_q);
        if (sel_kind_s != SEL_ONE) begin
            stab_cnt_d = '0;
        end else if (!same_s) begin
            stab_cnt_d = STAB_W'(1);
        end else if (stab_cnt_q != STAB_MAX) begin
            stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end else begin
            stab_cnt_d = stab_cnt_q;
        end
        capture_s = (sel_kind_s == SEL_ONE) && (stab_cnt_d == STAB_MAX) &&
                    (!same_s || (stab_cnt_q != STAB_MAX));
    end

    // Frame assembly, commit of shadows to outputs, and the sticky error flag
    always_comb begin
        commit_s    = (mask_q == 4'b1111);
        all_dec_s   = is_decimal(shadow_q[0]) && is_decimal(shadow_q[1]) &&
                      is_decimal(shadow_q[2]) && is_decimal(shadow_q[3]);
        all_blank_s = (shadow_q == {4{CODE_BLANK}});
        sum_s       = weighted_value(shadow_q[0], shadow_q[1], shadow_q[2], shadow_q[3]);

        mask_d        = mask_q;
        shadow_d      = shadow_q;
        val_d         = val_q;
        value_d       = value_q;
        value_ok_d    = value_ok_q;
        blank_frame_d = blank_frame_q;
        frame_done_d  = 1'b0;

        if (commit_s) begin
            mask_d        = 4'b0000;
            val_d         = shadow_q;
            value_ok_d    = all_dec_s;
            blank_frame_d = all_blank_s;
            frame_done_d  = 1'b1;
            if (all_dec_s) begin
                value_d = sum_s;
            end else begin
                value_d = value_q;
            end
        end else begin
            mask_d = mask_q;
        end

        // A capture on the commit cycle belongs to the next frame
        if (capture_s) begin
            mask_d[sel_idx_s]   = 1'b1;
            shadow_d[sel_idx_s] = dec_code_s;
        end else begin
            shadow_d = shadow_d;
        end

        seg_err_d = seg_err_q | (sel_kind_s == SEL_MULTI) | (capture_s & ~dec_valid_s);
    end

    // Timeout counter restarts on every capture and saturates at TIMEOUT_CYC
    always_comb begin
        if (capture_s) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q < TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
        stale_d = (tmo_cnt_d >= TMO_MAX);
    end

    // Sample and stability registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            samp_an_q  <= AN_IDLE;
            samp_seg_q <= SEG_BLANK;
            prev_an_q  <= AN_IDLE;
            prev_seg_q <= SEG_BLANK;
            stab_cnt_q <= '0;
        end else begin
            samp_an_q  <= samp_an_d;
            samp_seg_q <= samp_seg_d;
            prev_an_q  <= prev_an_d;
            prev_seg_q <= prev_seg_d;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    // Frame and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            mask_q        <= 4'b0000;
            shadow_q      <= {4{CODE_BLANK}};
            val_q         <= {4{CODE_BLANK}};
            value_q       <= 14'd0;
            value_ok_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            blank_frame_q <= 1'b0;
            seg_err_q     <= 1'b0;
        end else begin
            mask_q        <= mask_d;
            shadow_q      <= shadow_d;
            val_q         <= val_d;
            value_q       <= value_d;
            value_ok_q    <= value_ok_d;
            frame_done_q  <= frame_done_d;
            blank_frame_q <= blank_frame_d;
            seg_err_q     <= seg_err_d;
        end
    end

    // Timeout registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
            stale_q   <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            stale_q   <= stale_d;
        end
    end

    assign val1        = val_q[0];
    assign val2        = val_q[1];
    assign val3        = val_q[2];
    assign val4        = val_q[3];
    assign value       = value_q;
    assign value_ok    = value_ok_q;
    assign frame_done  = frame_done_q;
    assign blank_frame = blank_frame_q;
    assign seg_err     = seg_err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Self-checking bench for sevenseg_scan_decoder. Drives the anode/segment bus
// digit by digit and predicts every frame with a run-length reference model.
module tb_sevenseg_scan_decoder;

    localparam int STABLE = 4;
    localparam int TMO    = 300;

    logic        clk;
    logic        rst;
    logic        a1, a2, a3, a4;
    logic [6:0]  led_seg;
    logic [3:0]  val1, val2, val3, val4;
    logic [13:0] value;
    logic        value_ok, frame_done, blank_frame, seg_err, stale;

    int checks = 0;
    int errors = 0;
    int fd_count = 0;

    logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Reference model state
    logic [3:0] m_shadow [4];
    logic [3:0] m_val [4];
    logic [3:0] m_mask;
    int         m_value;
    logic       m_ok, m_blank, m_err;
    int         m_frames = 0;
    logic [3:0] run_an;
    logic [6:0] run_seg;
    int         run_len;

    sevenseg_scan_decoder #(
        .STABLE_CYC  (STABLE),
        .TIMEOUT_CYC (TMO),
        .CNT_W       (17)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a1          (a1),
        .a2          (a2),
        .a3          (a3),
        .a4          (a4),
        .led_seg     (led_seg),
        .val1        (val1),
        .val2        (val2),
        .val3        (val3),
        .val4        (val4),
        .value       (value),
        .value_ok    (value_ok),
        .frame_done  (frame_done),
        .blank_frame (blank_frame),
        .seg_err     (seg_err),
        .stale       (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame_done pulses
    always @(posedge clk) begin
        if (rst === 1'b1 && frame_done === 1'b1) fd_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] code_of(input logic [6:0] seg);
        logic [3:0] c;
        c = (seg == 7'h7F) ? 4'hF : 4'hE;
        for (int i = 0; i < 10; i++) if (segtab[i] == seg) c = 4'(i);
        return c;
    endfunction

    function automatic logic [6:0] rand_seg();
        int r;
        r = int'($urandom_range(0, 10));
        return (r == 10) ? 7'h7F : segtab[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin m_shadow[i] = 4'hF; m_val[i] = 4'hF; end
        m_mask = 4'b0000; m_value = 0; m_ok = 1'b0; m_blank = 1'b0; m_err = 1'b0;
        run_an = 4'hF; run_seg = 7'h7F; run_len = 0;
    endtask

    // A captured digit lands in its shadow; four distinct digits make a frame
    task automatic model_capture(input int idx, input logic [3:0] code);
        logic all_ok, all_blank;
        if (code == 4'hE) m_err = 1'b1;
        m_shadow[idx] = code;
        m_mask[idx]   = 1'b1;
        if (m_mask == 4'b1111) begin
            all_ok = 1'b1; all_blank = 1'b1;
            for (int i = 0; i < 4; i++) begin
                m_val[i] = m_shadow[i];
                if (m_shadow[i] > 4'd9) all_ok = 1'b0;
                if (m_shadow[i] != 4'hF) all_blank = 1'b0;
            end
            m_ok = all_ok; m_blank = all_blank;
            if (all_ok) m_value = int'(m_shadow[0]) * 1000 + int'(m_shadow[1]) * 100 +
                                  int'(m_shadow[2]) * 10 + int'(m_shadow[3]);
            m_frames++;
            m_mask = 4'b0000;
        end
    endtask

    // A digit is captured once when an unbroken single-anode run reaches STABLE cycles
    task automatic model_step(input logic [3:0] an, input logic [6:0] seg, input int n);
        int prev_len, lows, idx;
        if (an == run_an && seg == run_seg) begin
            prev_len = run_len; run_len = run_len + n;
        end else begin
            prev_len = 0; run_len = n; run_an = an; run_seg = seg;
        end
        lows = 0; idx = 0;
        for (int i = 0; i < 4; i++) if (an[i] == 1'b0) begin lows++; idx = i; end
        if (lows >= 2) m_err = 1'b1;
        if (lows == 1 && prev_len < STABLE && run_len >= STABLE) model_capture(idx, code_of(seg));
    endtask

    // an is {a4,a3,a2,a1}; entered and left on a falling clock edge
    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        {a4, a3, a2, a1} = an;
        led_seg = seg;
        model_step(an, seg, n);
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input int d, input logic [6:0] seg, input int n);
        logic [3:0] an;
        an = 4'b1111;
        an[d-1] = 1'b0;
        drive(an, seg, n);
    endtask

    task automatic idle(input int n);
        drive(4'b1111, 7'h7F, n);
    endtask

    task automatic scan4(input logic [6:0] s1, input logic [6:0] s2,
                         input logic [6:0] s3, input logic [6:0] s4, input int n);
        show(1, s1, n); show(2, s2, n); show(3, s3, n); show(4, s4, n);
        idle(4);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        {a4, a3, a2, a1} = 4'b1111;
        led_seg = 7'h7F;
        repeat (n) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic check_all(input string tag);
        check({tag, ".val1"}, 32'(val1), 32'(m_val[0]));
        check({tag, ".val2"}, 32'(val2), 32'(m_val[1]));
        check({tag, ".val3"}, 32'(val3), 32'(m_val[2]));
        check({tag, ".val4"}, 32'(val4), 32'(m_val[3]));
        check({tag, ".value"}, 32'(value), 32'(m_value));
        check({tag, ".value_ok"}, 32'(value_ok), 32'(m_ok));
        check({tag, ".blank_frame"}, 32'(blank_frame), 32'(m_blank));
        check({tag, ".seg_err"}, 32'(seg_err), 32'(m_err));
        check({tag, ".frames"}, 32'(fd_count), 32'(m_frames));
        check({tag, ".frame_done_idle"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        int ord [4];
        int k, j, t;
        rst = 1'b0;
        {a4, a3, a2, a1} = 4'b1111;
        led_seg = 7'h7F;
        model_reset();
        @(negedge clk);
        do_reset(3);

        // Reset state
        check_all("reset");
        check("reset.value_const", 32'(value), 32'd0);
        check("reset.val1_const", 32'(val1), 32'hF);
        check("reset.stale", 32'(stale), 32'd0);

        // "0186"
        scan4(7'h40, 7'h79, 7'h00, 7'h02, 8);
        check_all("f0186");
        check("f0186.value_const", 32'(value), 32'd186);

        // "9999" then "0416"
        scan4(7'h10, 7'h10, 7'h10, 7'h10, 8);
        check_all("f9999");
        check("f9999.value_const", 32'(value), 32'd9999);
        scan4(7'h40, 7'h19, 7'h79, 7'h02, 8);
        check_all("f0416");
        check("f0416.value_const", 32'(value), 32'd416);

        // Blink-off frame holds the last value
        scan4(7'h7F, 7'h7F, 7'h7F, 7'h7F, 8);
        check_all("blank");
        check("blank.flag_const", 32'(blank_frame), 32'd1);
        check("blank.value_hold", 32'(value), 32'd416);

        // Dwell one short of STABLE: nothing captured
        scan4(7'h24, 7'h30, 7'h12, 7'h78, STABLE - 1);
        check_all("short_dwell");
        check("short_dwell.value_hold", 32'(value), 32'd416);
        scan4(7'h24, 7'h30, 7'h12, 7'h78, STABLE);
        check_all("exact_dwell");
        check("exact_dwell.value_const", 32'(value), 32'd2357);

        // Randomized frames: extra overwriting captures, glitches, random order
        for (int f = 0; f < 30; f++) begin
            k = int'($urandom_range(0, 2));
            for (int e = 0; e < k; e++)
                show(int'($urandom_range(1, 4)), rand_seg(), int'($urandom_range(STABLE, STABLE + 3)));
            for (int i = 0; i < 4; i++) ord[i] = i + 1;
            for (int i = 3; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0)
                    show(int'($urandom_range(1, 4)), segtab[$urandom_range(0, 9)],
                         int'($urandom_range(1, STABLE - 1)));
                show(ord[i], rand_seg(), int'($urandom_range(STABLE, STABLE + 4)));
            end
            idle(4);
            check_all($sformatf("rand%0d", f));
        end

        // Stale timeout
        idle(250);
        check("stale.before", 32'(stale), 32'd0);
        idle(60);
        check("stale.set", 32'(stale), 32'd1);
        show(1, 7'h30, STABLE - 1);
        check("stale.no_capture_yet", 32'(stale), 32'd1);
        show(1, 7'h30, 1);
        idle(2);
        check("stale.cleared", 32'(stale), 32'd0);

        // Anode collision and an invalid pattern
        drive(4'b1010, 7'h40, 8);
        idle(2);
        check("collision.seg_err", 32'(seg_err), 32'd1);
        check("collision.model_err", 32'(seg_err), 32'(m_err));
        scan4(7'h79, 7'h55, 7'h24, 7'h30, 8);
        check_all("badpat");
        check("badpat.val2_const", 32'(val2), 32'hE);
        check("badpat.value_ok", 32'(value_ok), 32'd0);

        // Reset in the middle of a frame
        show(1, 7'h12, 6);
        show(2, 7'h78, 6);
        do_reset(2);
        check_all("midreset");
        check("midreset.seg_err", 32'(seg_err), 32'd0);
        check("midreset.stale", 32'(stale), 32'd0);
        show(2, 7'h00, 6); show(3, 7'h79, 6); show(4, 7'h19, 6);
        idle(4);
        check_all("midreset.partial");
        show(1, 7'h10, 6);
        idle(4);
        check_all("midreset.commit");
        check("midreset.value_const", 32'(value), 32'd9814);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_decoder.md
Name: sevenseg_scan_decoder

Overview:
Receive-side counterpart of the parking-meter display driver. Samples the multiplexed anode/segment bus (a1..a4, led_seg) and rebuilds the four displayed digits. Also reports the 0–9999 binary value, blank (blink-off) frames and stale/invalid display conditions. Used as an on-chip self-check monitor and as a display-to-value bridge for the meter bench.

Parameters:
STABLE_CYC, 4, consecutive identical samples needed before a digit is captured (anti-ghosting)
TIMEOUT_CYC, 100000, cycles without any capture before stale asserts
CNT_W, 17, width of the timeout counter; must hold TIMEOUT_CYC

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
a1  in  1  anode, digit 1 (most significant), active-low
a2  in  1  anode, digit 2, active-low
a3  in  1  anode, digit 3, active-low
a4  in  1  anode, digit 4 (least significant), active-low
led_seg  in  7  segments {g,f,e,d,c,b,a}, active-low
val1  out  4  digit 1 code: 0–9, 4'hE invalid pattern, 4'hF blank
val2  out  4  digit 2 code, same encoding
val3  out  4  digit 3 code, same encoding
val4  out  4  digit 4 code, same encoding
value  out  14  val1*1000+val2*100+val3*10+val4
value_ok  out  1  all four of val1..val4 are in 0–9
frame_done  out  1  one-cycle pulse when val*/value update
blank_frame  out  1  last committed frame had all four digits blank
seg_err  out  1  sticky; set on an invalid pattern or on more than one anode low
stale  out  1  no digit captured for TIMEOUT_CYC cycles

Behaviour:
- Reset (rst==0 at a clk edge) takes priority over everything else, including mid-frame.
  - val1..val4 = 4'hF; value = 0.
  - value_ok, frame_done, blank_frame, seg_err, stale = 0.
  - Capture mask, stability counter and timeout counter cleared.
- Each cycle, register {a1..a4, led_seg} once (sample stage). All decisions below use the registered copy.
- Anode select:
  - Exactly one anode low: legal sample.
  - All anodes high: idle. The stability counter clears.
  - Two or more anodes low: stability counter clears, seg_err sets.
- Stability: the counter increments while the sample is legal and both anode and segments equal the previous sample. Any change reloads it to 1. When it reaches STABLE_CYC:
  - The digit is captured into a shadow register.
  - Its capture-mask bit sets.
  - The counter saturates, so the same digit is captured only once per dwell.
- Pattern decode (active-low, bit0 = a):
  - 0:7'h40, 1:7'h79, 2:7'h24, 3:7'h30, 4:7'h19, 5:7'h12, 6:7'h02, 7:7'h78, 8:7'h00, 9:7'h10.
  - 7'h7F decodes to blank (4'hF).
  - Any other pattern decodes to 4'hE and sets seg_err.
- A digit captured again before its frame completes overwrites its shadow value.
- Frame commit: on the cycle after the capture mask reaches 4'b1111:
  - Shadow values are copied to val1..val4.
  - value and value_ok are computed combinationally from the shadows and registered together with val*.
  - frame_done pulses for 1 cycle; the mask clears.
  - blank_frame = (all four shadows == 4'hF).
  - Capture and commit in the same cycle: the new capture goes into the next frame's mask.
- value arithmetic: 14-bit unsigned. If value_ok == 0, value holds its previous value.
- Latency: 1 sample cycle + STABLE_CYC cycles to capture the last digit, then 1 cycle to commit.
- Timeout: the counter clears on any capture and otherwise counts up, saturating. stale = 1 while count ≥ TIMEOUT_CYC; it drops the cycle after the next capture.
- seg_err clears only on reset.

Decomposition:
- Package sevenseg_pkg:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK
  - digit codes CODE_BLANK = 4'hF and CODE_BAD = 4'hE
  - anode active level
- Sub-module seg7_to_bcd: combinational pattern→code decoder with a valid flag. The same patterns are shared with the meter's encoder via the package.
- Top level holds the sample register, stability counter, capture mask and frame commit, timeout counter, and the weighted-sum value.

Test Plan:
- Reset, then scan "0186" (a1..a4 each low for 8 cycles, patterns 40/79/00/02) → frame_done pulses; val = 0,1,8,6; value = 186; value_ok = 1.
- Scan "9999", then "0416" → value 9999, then 416. value_ok stays 1; no seg_err.
- All four digits show 7'h7F (blink-off) → val* = F; blank_frame = 1; value_ok = 0; value holds the last value (416).
- Dwell of STABLE_CYC−1 cycles per anode → no capture and no frame_done. Bump the dwell to STABLE_CYC → frame commits.
- a1 and a3 low together, then pattern 7'h55 on a2 → seg_err = 1; val2 = E after the frame. seg_err persists until rst = 0.
- Hold all anodes high for TIMEOUT_CYC cycles → stale = 1. Resume scanning → stale = 0 after the first capture. Assert rst mid-frame → all outputs return to their reset values and the mask clears.
